// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged, clock-aligned reset generator for multiple domains
//
// Purpose:
//   Collects reset requests (asynchronous level request, synchronous software
//   strobe, and this block's own reset), asserts every domain reset together,
//   holds them while the request persists plus HOLD_CYCLES, then releases the
//   domains one at a time, STEP_CYCLES apart, bit 0 first. Every output comes
//   straight from a flop, so downstream async-reset banks see clean,
//   clock-aligned deassertion.
//
// Ports:
//   clk        in   1            single clock
//   rst        in   1            synchronous active-high reset of this block
//   req        in   1            asynchronous active-high level request
//   sw_req     in   1            synchronous single-cycle request strobe
//   rst_out    out  NUM_DOMAINS  active-high domain resets (registered)
//   busy       out  1            high while any rst_out bit is high
//   done       out  1            one-cycle pulse when the last domain releases
//   req_count  out  8            saturating count of request events

module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int SYNC_STAGES = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   sw_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             req_count
);

  // Counter must reach max(HOLD_CYCLES, STEP_CYCLES) - 1.
  localparam int MAX_CYC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [NUM_DOMAINS-1:0] r_rst_out;
  logic                   r_busy;
  logic                   r_done;
  logic [7:0]             r_req_count;

  logic w_req_s;
  logic w_any_req;

  assign w_req_s   = r_sync[SYNC_STAGES-1];
  // A synchronized level request and a strobe in the same cycle are one event.
  assign w_any_req = w_req_s | sw_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= '0;
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_out   <= '1;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_req_count <= 8'd0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req};
      r_done <= 1'b0;

      case (r_state)
        ST_HOLD: begin
          // Any pending request stretches the hold: restart the count
          // without treating it as a new event.
          if (w_any_req) begin
            r_cnt <= '0;
          end else if (r_cnt == HOLD_LAST) begin
            r_rst_out[0] <= 1'b0;
            r_cnt        <= '0;
            r_idx        <= IW'(1);
            if (NUM_DOMAINS == 1) begin
              r_state <= ST_RUN;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_RELEASE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_RELEASE: begin
          if (w_any_req) begin
            r_rst_out <= '1;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_HOLD;
            if (r_req_count != 8'hFF) r_req_count <= r_req_count + 8'd1;
          end else if (r_cnt == STEP_LAST) begin
            r_rst_out[r_idx] <= 1'b0;
            r_cnt            <= '0;
            r_idx            <= r_idx + IW'(1);
            // Clearing the last bit empties rst_out in the same edge.
            if (r_idx == IDX_LAST) begin
              r_state <= ST_RUN;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_RUN: begin
          if (w_any_req) begin
            r_rst_out <= '1;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_HOLD;
            if (r_req_count != 8'hFF) r_req_count <= r_req_count + 8'd1;
          end
        end

        default: begin
          r_rst_out <= '1;
          r_busy    <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_HOLD;
        end
      endcase
    end
  end

  assign rst_out   = r_rst_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign req_count = r_req_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer

module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       sw_req = 1'b0;
  logic [3:0] rst_out;
  logic       busy;
  logic       done;
  logic [7:0] req_count;

  reset_sequencer #(
    .NUM_DOMAINS(4),
    .SYNC_STAGES(3),
    .HOLD_CYCLES(16),
    .STEP_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .sw_req(sw_req),
    .rst_out(rst_out),
    .busy(busy),
    .done(done),
    .req_count(req_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         c;
    int         tag;
    logic [3:0] r;
    logic       b;
    logic       d;
    logic [7:0] n;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic push(input int c, input int tag, input logic [3:0] r,
                      input logic b, input logic d, input logic [7:0] n);
    exp_t e;
    e.c = c; e.tag = tag; e.r = r; e.b = b; e.d = d; e.n = n;
    q.push_back(e);
  endtask

  // Hand-computed release profile with cycle 0 at base (HOLD 16, STEP 8).
  task automatic seq_expect(input int base, input int tag, input logic [7:0] n);
    push(base,      tag, 4'b1111, 1'b1, 1'b0, n);
    push(base + 15, tag, 4'b1111, 1'b1, 1'b0, n);
    push(base + 16, tag, 4'b1110, 1'b1, 1'b0, n);
    push(base + 23, tag, 4'b1110, 1'b1, 1'b0, n);
    push(base + 24, tag, 4'b1100, 1'b1, 1'b0, n);
    push(base + 31, tag, 4'b1100, 1'b1, 1'b0, n);
    push(base + 32, tag, 4'b1000, 1'b1, 1'b0, n);
    push(base + 39, tag, 4'b1000, 1'b1, 1'b0, n);
    push(base + 40, tag, 4'b0000, 1'b0, 1'b1, n);
    push(base + 41, tag, 4'b0000, 1'b0, 1'b0, n);
  endtask

  // Monitor: every cycle the outputs are presented; pop whatever is due.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (cyc > 0) begin
        checks++;
        if (busy !== (rst_out != 4'b0000)) begin
          errors++;
          $display("FAIL busy_vs_rst_out cyc=%0d busy=%b rst_out=%b", cyc, busy, rst_out);
        end
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].c <= cyc) begin
          checks++;
          if (q[i].c < cyc) begin
            errors++;
            $display("FAIL snap_t%0d missed cyc=%0d", q[i].tag, q[i].c);
          end else if ({rst_out, busy, done, req_count} !== {q[i].r, q[i].b, q[i].d, q[i].n}) begin
            errors++;
            $display("FAIL snap_t%0d cyc=%0d got rst_out=%b busy=%b done=%b cnt=%0d want rst_out=%b busy=%b done=%b cnt=%0d",
                     q[i].tag, cyc, rst_out, busy, done, req_count, q[i].r, q[i].b, q[i].d, q[i].n);
          end
          q.delete(i);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    int base;
    int r;
    logic [7:0] mcount;

    // 1: power-up
    rst = 1'b1;
    step(); step();
    push(cyc, 0, 4'b1111, 1'b1, 1'b0, 8'd0);
    step(); step(); step();
    rst = 1'b0;
    base = cyc;
    seq_expect(base, 1, 8'd0);
    wait_to(base + 45);

    // 2: sw_req in RUN
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    seq_expect(cyc, 2, 8'd1);
    wait_to(cyc + 45);

    // 3: async req held 20 cycles
    r = cyc;
    req = 1'b1;
    push(r + 3, 30, 4'b0000, 1'b0, 1'b0, 8'd1);
    push(r + 4, 31, 4'b1111, 1'b1, 1'b0, 8'd2);
    push(r + 22, 32, 4'b1111, 1'b1, 1'b0, 8'd2);
    wait_to(r + 20);
    req = 1'b0;
    seq_expect(r + 23, 3, 8'd2);
    wait_to(r + 23 + 45);

    // 4: request during RELEASE at 1100
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    base = cyc;
    push(base, 40, 4'b1111, 1'b1, 1'b0, 8'd3);
    push(base + 16, 41, 4'b1110, 1'b1, 1'b0, 8'd3);
    push(base + 26, 42, 4'b1100, 1'b1, 1'b0, 8'd3);
    wait_to(base + 26);
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    seq_expect(cyc, 4, 8'd4);
    wait_to(cyc + 45);

    // 5: simultaneous req_s and sw_req count once, then saturation
    r = cyc;
    req = 1'b1;
    step();
    req = 1'b0;
    wait_to(r + 3);
    push(r + 3, 51, 4'b0000, 1'b0, 1'b0, 8'd4);
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    base = cyc;
    push(base, 50, 4'b1111, 1'b1, 1'b0, 8'd5);
    push(base + 1, 50, 4'b1111, 1'b1, 1'b0, 8'd5);
    mcount = 8'd5;
    for (int i = 0; i < 300; i++) begin
      wait_to(base + 16);
      push(base + 16, 52, 4'b1110, 1'b1, 1'b0, mcount);
      sw_req = 1'b1;
      step();
      sw_req = 1'b0;
      if (mcount != 8'd255) mcount = mcount + 8'd1;
      base = base + 17;
      push(base, 53, 4'b1111, 1'b1, 1'b0, mcount);
    end
    push(base + 5, 54, 4'b1111, 1'b1, 1'b0, 8'd255);

    // 6: rst mid-RELEASE
    wait_to(base + 20);
    push(base + 20, 60, 4'b1110, 1'b1, 1'b0, 8'd255);
    rst = 1'b1;
    step();
    push(cyc, 61, 4'b1111, 1'b1, 1'b0, 8'd0);
    step(); step();
    rst = 1'b0;
    base = cyc;
    seq_expect(base, 6, 8'd0);
    wait_to(base + 45);
    step(); step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expects got %0d want 0", q.size());
    end
    checks++;
    if (done_seen != 5) begin
      errors++;
      $display("FAIL done_pulses got %0d want 5", done_seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
